led_display_pattern_gen_bcm: RTL

//  Parametrised multi-bit-colour test-pattern source for the HUB75 display path. Emits row beats
//  (top+bottom half rows) over valid/ready to the display PHY, one beat per (row address, bit plane)
//  for binary-code-modulation. Generalises the 1-bit generator: any panel size, COLOUR_DEPTH planes,

---
 rtl/led_display_package.sv | 30 +++
 rtl/led_display_frame_ctr.sv | 113 +++++++++++
 rtl/led_display_pattern_gen_bcm.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/led_display_package.sv
// Shared definitions for the HUB75 BCM pattern generator.
//   mode_e        : pattern mode codes carried on mode_in (4 bits)
//   CH_*          : channel indices inside colour_in and inside each row half
//   HALF_*        : row half indices (top = lower panel rows)
//   row_bit_index : position of (half, channel, column) in the packed row word,
//                   giving {bot.b,bot.g,bot.r,top.b,top.g,top.r}, bit c = column c
package led_display_package;

  typedef enum logic [3:0] {
    MODE_OFF      = 4'd0,
    MODE_SOLID    = 4'd1,
    MODE_SCAN_H   = 4'd2,
    MODE_SCAN_V   = 4'd3,
    MODE_PULSE    = 4'd4,
    MODE_GRADIENT = 4'd5
  } mode_e;

  localparam int unsigned NUM_CHANNELS = 3;
  localparam int unsigned CH_RED       = 0;
  localparam int unsigned CH_GREEN     = 1;
  localparam int unsigned CH_BLUE      = 2;
  localparam int unsigned HALF_TOP     = 0;
  localparam int unsigned HALF_BOT     = 1;

  function automatic int unsigned row_bit_index(input int unsigned half, input int unsigned ch,
                                                input int unsigned col, input int unsigned num_cols);
    return (half * NUM_CHANNELS + ch) * num_cols + col;
  endfunction

endpackage

// File: rtl/led_display_frame_ctr.sv
// Beat / frame sequencing for the BCM pattern generator.
//   clk_in, reset_in : clock, asynchronous active-high reset
//   clear            : synchronous clear of every counter (mode change)
//   advance          : current beat accepted, move to the next one
//   scan_max         : wrap value of the scan position
//   addr_nxt/plane_nxt/scan_pos_nxt/pulse_lvl_nxt : counter values after this edge
//   frame_end        : this edge accepts the last beat of a frame
module led_display_frame_ctr #(
  parameter int unsigned NUM_ADDR   = 16,
  parameter int unsigned NUM_PLANES = 4,
  parameter int unsigned AW         = 4,
  parameter int unsigned PW         = 2,
  parameter int unsigned SW         = 6,
  parameter int unsigned LW         = 4,
  parameter int unsigned SCAN_DIV   = 60,
  parameter int unsigned PULSE_DIV  = 8
)(
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          clear,
  input  logic          advance,
  input  logic [SW-1:0] scan_max,
  output logic [AW-1:0] addr_nxt,
  output logic [PW-1:0] plane_nxt,
  output logic [SW-1:0] scan_pos_nxt,
  output logic [LW-1:0] pulse_lvl_nxt,
  output logic          frame_end
);

  logic [AW-1:0] addr_q;
  logic [PW-1:0] plane_q;
  logic [SW-1:0] scan_q;
  logic [LW-1:0] lvl_q, lvl_n;
  logic          dir_q, dir_n;
  logic [31:0]   sdiv_q, sdiv_n, pdiv_q, pdiv_n;

  // Counters hold the coordinates of the beat on the outputs; the *_nxt values
  // feed the beat computed on the same edge, so a frame step is already visible
  // in the first beat of the following frame.
  always_comb begin
    addr_nxt      = addr_q;
    plane_nxt     = plane_q;
    scan_pos_nxt  = scan_q;
    lvl_n         = lvl_q;
    dir_n         = dir_q;
    sdiv_n        = sdiv_q;
    pdiv_n        = pdiv_q;
    frame_end     = 1'b0;
    if (clear) begin
      addr_nxt     = '0;
      plane_nxt    = '0;
      scan_pos_nxt = '0;
      lvl_n        = '0;
      dir_n        = 1'b0;
      sdiv_n       = '0;
      pdiv_n       = '0;
    end else if (advance) begin
      if (plane_q == PW'(NUM_PLANES - 1)) begin
        plane_nxt = '0;
        if (addr_q == AW'(NUM_ADDR - 1)) begin
          addr_nxt  = '0;
          frame_end = 1'b1;
          if (sdiv_q == SCAN_DIV - 1) begin
            sdiv_n       = '0;
            scan_pos_nxt = (scan_q == scan_max) ? '0 : scan_q + 1'b1;
          end else begin
            sdiv_n = sdiv_q + 32'd1;
          end
          // Triangle: the extreme value is held for one extra step while turning.
          if (pdiv_q == PULSE_DIV - 1) begin
            pdiv_n = '0;
            if (!dir_q) begin
              if (lvl_q == '1) dir_n = 1'b1;
              else             lvl_n = lvl_q + 1'b1;
            end else begin
              if (lvl_q == '0) dir_n = 1'b0;
              else             lvl_n = lvl_q - 1'b1;
            end
          end else begin
            pdiv_n = pdiv_q + 32'd1;
          end
        end else begin
          addr_nxt = addr_q + 1'b1;
        end
      end else begin
        plane_nxt = plane_q + 1'b1;
      end
    end
  end

  assign pulse_lvl_nxt = lvl_n;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      addr_q  <= '0;
      plane_q <= '0;
      scan_q  <= '0;
      lvl_q   <= '0;
      dir_q   <= 1'b0;
      sdiv_q  <= '0;
      pdiv_q  <= '0;
    end else begin
      addr_q  <= addr_nxt;
      plane_q <= plane_nxt;
      scan_q  <= scan_pos_nxt;
      lvl_q   <= lvl_n;
      dir_q   <= dir_n;
      sdiv_q  <= sdiv_n;
      pdiv_q  <= pdiv_n;
    end
  end

endmodule

// File: rtl/led_display_pattern_gen_bcm.sv
// Multi-bit-colour BCM test-pattern source for the HUB75 path.
// One valid/ready beat per (row address, bit plane); plane runs fastest.
//   clk_in, reset_in  : clock, asynchronous active-high reset
//   mode_in           : pattern mode (mode_e codes)
//   colour_in         : {blue,green,red} levels, red in LSBs
//   row_out           : {bot.b,bot.g,bot.r,top.b,top.g,top.r}, bit c = column c
//   row_valid_out / row_ready_in : beat handshake
//   row_address_out, plane_out   : coordinates of the beat
//   frame_done_out    : pulse after the last beat of a frame is accepted
// Build option: LED_PATTERN_GEN_GRADIENT_EN enables MODE_GRADIENT (otherwise it acts as MODE_OFF).
module led_display_pattern_gen_bcm #(
  parameter  int unsigned NUM_ROW_PIXELS = 32,
  parameter  int unsigned NUM_COL_PIXELS = 64,
  parameter  int unsigned COLOUR_DEPTH   = 4,
  parameter  int unsigned SCAN_DIV       = 60,
  parameter  int unsigned PULSE_DIV      = 8,
  localparam int unsigned AW = ((NUM_ROW_PIXELS / 2) > 1) ? $clog2(NUM_ROW_PIXELS / 2) : 1,
  localparam int unsigned PW = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1
)(
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [3:0]                  mode_in,
  input  logic [3*COLOUR_DEPTH-1:0]   colour_in,
  output logic [6*NUM_COL_PIXELS-1:0] row_out,
  output logic                        row_valid_out,
  input  logic                        row_ready_in,
  output logic [AW-1:0]               row_address_out,
  output logic [PW-1:0]               plane_out,
  output logic                        frame_done_out
);
  import led_display_package::*;

  localparam int unsigned HALF_ROWS = NUM_ROW_PIXELS / 2;
  localparam int unsigned CW        = $clog2(NUM_COL_PIXELS);
  localparam int unsigned RW        = $clog2(NUM_ROW_PIXELS);
  localparam int unsigned SW        = (CW > RW) ? CW : RW;
`ifdef LED_PATTERN_GEN_GRADIENT_EN
  localparam int unsigned GSHIFT    = CW - COLOUR_DEPTH;
`endif

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e                      state;
  logic [3:0]                  mode_q, mode_prev;
  logic                        mode_change, advance, frame_end;
  logic [AW-1:0]               addr_nxt;
  logic [PW-1:0]               plane_nxt;
  logic [SW-1:0]               scan_nxt, scan_max;
  logic [COLOUR_DEPTH-1:0]     pulse_nxt;
  logic [6*NUM_COL_PIXELS-1:0] row_nxt;

  assign mode_change = (mode_q != mode_prev);
  assign advance     = (state == ST_RUN) && row_valid_out && row_ready_in;
  assign scan_max    = (mode_q == MODE_SCAN_H) ? SW'(NUM_COL_PIXELS - 1) : SW'(NUM_ROW_PIXELS - 1);

  function automatic logic pixel_bit(input logic [3:0] mode, input logic [COLOUR_DEPTH-1:0] chan,
                                     input logic [SW-1:0] col, input logic [SW-1:0] prow,
                                     input logic [SW-1:0] scan, input logic [COLOUR_DEPTH-1:0] pulse,
                                     input logic [PW-1:0] plane);
    logic [COLOUR_DEPTH-1:0] lvl;
    lvl = '0;
    case (mode)
      MODE_SOLID:    lvl = chan;
      MODE_SCAN_H:   if (col == scan)  lvl = chan;
      MODE_SCAN_V:   if (prow == scan) lvl = chan;
      MODE_PULSE:    if (chan != '0)   lvl = pulse;
`ifdef LED_PATTERN_GEN_GRADIENT_EN
      MODE_GRADIENT: if (chan != '0)   lvl = COLOUR_DEPTH'(col >> GSHIFT);
`endif
      default:       lvl = '0;
    endcase
    return lvl[plane];
  endfunction

  led_display_frame_ctr #(
    .NUM_ADDR   (HALF_ROWS),
    .NUM_PLANES (COLOUR_DEPTH),
    .AW         (AW),
    .PW         (PW),
    .SW         (SW),
    .LW         (COLOUR_DEPTH),
    .SCAN_DIV   (SCAN_DIV),
    .PULSE_DIV  (PULSE_DIV)
  ) u_frame_ctr (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .clear         (mode_change),
    .advance       (advance),
    .scan_max      (scan_max),
    .addr_nxt      (addr_nxt),
    .plane_nxt     (plane_nxt),
    .scan_pos_nxt  (scan_nxt),
    .pulse_lvl_nxt (pulse_nxt),
    .frame_end     (frame_end)
  );

  for (genvar h = HALF_TOP; h <= HALF_BOT; h++) begin : g_half
    logic [SW-1:0] prow;
    assign prow = SW'(h * HALF_ROWS) + SW'(addr_nxt);
    for (genvar ch = CH_RED; ch <= CH_BLUE; ch++) begin : g_chan
      for (genvar c = 0; c < NUM_COL_PIXELS; c++) begin : g_col
        assign row_nxt[row_bit_index(h, ch, c, NUM_COL_PIXELS)] =
          pixel_bit(mode_q, colour_in[ch*COLOUR_DEPTH +: COLOUR_DEPTH], SW'(c), prow,
                    scan_nxt, pulse_nxt, plane_nxt);
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state           <= ST_LOAD;
      mode_q          <= '0;
      mode_prev       <= '0;
      row_out         <= '0;
      row_valid_out   <= 1'b0;
      row_address_out <= '0;
      plane_out       <= '0;
      frame_done_out  <= 1'b0;
    end else begin
      mode_q         <= mode_in;
      mode_prev      <= mode_q;
      frame_done_out <= frame_end;
      if (mode_change) begin
        // Any pending beat is dropped; the frame restarts from addr 0 / plane 0.
        state           <= ST_LOAD;
        row_valid_out   <= 1'b0;
        row_address_out <= '0;
        plane_out       <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            state           <= ST_RUN;
            row_valid_out   <= 1'b1;
            row_out         <= row_nxt;
            row_address_out <= addr_nxt;
            plane_out       <= plane_nxt;
          end
          default: begin
            if (advance) begin
              row_out         <= row_nxt;
              row_address_out <= addr_nxt;
              plane_out       <= plane_nxt;
            end
          end
        endcase
      end
    end
  end

endmodule
